vec_uop_sequencer: RTL and testbench
====================================

Name: vec_uop_sequencer

Overview:
Vector-extension successor to the scalar control decoder. It holds the vector configuration (vl, vtype) and decodes vsetvli and vsetivli. It cracks unit-stride vector loads and stores and OPIVV/OPIVX/OPIVI arithmetic into LANES-wide micro-ops. Micro-ops issue over a valid/ready handshake to the vector lanes and the vector LSU. It sits between fetch/decode issue and the vector execution back end.

Parameters:
VLEN, 128, vector register width in bits (power of 2, ≥ 32·LANES)
LANES, 4, elements per micro-op (power of 2)
XLEN, 32, scalar width
VLW, $clog2(VLEN)+1, width of vl and element indices

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  sequencer can accept an instruction (state IDLE)
- Instr  in  32  instruction word
- Rs1Data  in  XLEN  scalar rs1 value; AVL or base address/scalar operand
- uop_valid  out  1  micro-op valid
- uop_ready  in  1  back end accepts the micro-op
- UopType  out  2  0 = ALU, 1 = load, 2 = store
- Funct6, Funct3  out  6, 3  passed through from Instr
- VdIdx, Vs1Idx, Vs2Idx  out  5 each  physical register of this micro-op
- ElemBase  out  VLW  index of the first element covered by lane 0
- ElemMask  out  LANES  lane i active iff ElemBase+i < vl
- Sew  out  2  0 = e8, 1 = e16, 2 = e32
- ScalarOpd  out  XLEN  latched Rs1Data (.vx, load, store) or sign-extended simm5 (.vi)
- VRegWrite, VMemRead, VMemWrite  out  1 each  micro-op control
- UopLast  out  1  last micro-op of the instruction
- Vl  out  VLW  current vl
- Vill  out  1  vtype illegal
- RdWrite  out  1  one-cycle pulse; write RdData to x[rd]
- RdData  out  XLEN  new vl, zero-extended
- InstrDone  out  1  one-cycle retirement pulse
- IllegalInstr  out  1  one-cycle illegal-instruction pulse

Behaviour:
- Reset (rst_n = 0 at posedge): state IDLE, Vl = 0, Vill = 1, vtype = 0, all pulses and uop_valid at 0. Reset mid-issue drops the in-flight instruction without a done pulse.
- An instruction is accepted on a cycle with in_valid & in_ready.
- All outputs are registered. Pulses appear in the cycle after the accept or the last handshake.

vsetvli and vsetivli:
- Decode: opcode 1010111, funct3 111.
  - vsetvli: Instr[31] = 0, zimm = Instr[30:20].
  - vsetivli: Instr[31:30] = 11, AVL = Instr[19:15].
  - vsetvl (Instr[31:30] = 10) is illegal.
- vsew = zimm[5:3] and vlmul = zimm[2:0]. vsew > 2 or vlmul[2] = 1 sets Vill = 1 and Vl = 0.
- Otherwise VLMAX = (VLEN·2^vlmul) >> (3+vsew).
- vsetvli AVL selection:
  - rs1 ≠ 0: AVL = Rs1Data.
  - rs1 = 0, rd ≠ 0: AVL = VLMAX.
  - rs1 = 0, rd = 0: AVL = the old Vl.
- Vl = min(AVL, VLMAX), with the full XLEN comparison.
- Completes in one cycle. The next cycle has RdWrite = (rd ≠ 0), RdData = new Vl, InstrDone = 1.
- in_ready stays 1, so back-to-back vset instructions are allowed.
- An instruction accepted in the following cycle sees the new Vl.

Vector ops:
- ALU: opcode 1010111, funct3 000/100/011.
- Load: opcode 0000111. Store: opcode 0100111.
- Load and store are legal only with mop = 00, lumop/sumop = 0, nf = 0, and width 000/101/110 encoding EEW equal to SEW.
- Any of the following raises IllegalInstr with no micro-op:
  - vm = 0 (Instr[25]);
  - Vill = 1;
  - a vd, vs1 or vs2 actually used that is not a multiple of 2^vlmul;
  - an unsupported encoding.
- vl = 0: no micro-op; InstrDone in the next cycle.
- Otherwise the block enters ISSUE with N = ceil(vl/LANES) micro-ops, k = 0..N-1.
  - ElemBase = k·LANES.
  - Register offset = ElemBase >> (log2(VLEN)-3-sew). VdIdx, Vs1Idx and Vs2Idx = field + offset.
  - Stores carry vs3 in VdIdx.
- ISSUE handshake:
  - uop_valid = 1 and all fields stay stable until uop_ready.
  - On each handshake the next micro-op is presented in the next cycle with no bubble.
  - The handshake with UopLast = 1 returns the block to IDLE; InstrDone pulses in the next cycle.
  - in_ready = 0 throughout ISSUE.
- Control flags:
  - ALU: VRegWrite = 1.
  - Load: VRegWrite = 1, VMemRead = 1.
  - Store: VMemWrite = 1.
- Unrecognised opcodes: IllegalInstr.

Test Plan (VLEN = 128, LANES = 4):
1. Reset 2 cycles, then vadd.vv v1,v2,v3 → Vl = 0, Vill = 1, in_ready = 1; IllegalInstr pulses; no uop_valid.
2. vsetvli x5,x6,e32,m2 with Rs1Data = 10 → Vl = 8, Vill = 0, RdWrite = 1, RdData = 8 for one cycle. Then vsetvli x0,x0 → Vl stays 8, RdWrite = 0.
3. At vl = 8, e32/m2: vadd.vv v4,v8,v12 with uop_ready = 1 → 2 micro-ops, one per cycle:
   - ElemBase 0, then 4;
   - VdIdx 4, 5; Vs2Idx 8, 9; Vs1Idx 12, 13;
   - ElemMask 1111 on both; UopLast on the 2nd;
   - InstrDone pulses the next cycle.
4. vsetivli x0,6,e8,m1, then vle8.v v2,(x1) with Rs1Data = 0x1000 → 2 micro-ops:
   - ElemMask 1111, then 0011;
   - VdIdx 2, 2;
   - VMemRead = 1, ScalarOpd = 0x1000.
5. Hold uop_ready = 0 for 3 cycles mid-instruction → all fields frozen and no advance. Assert rst_n = 0 during ISSUE → uop_valid = 0 next cycle, Vill = 1, no InstrDone.
6. vsetvli with e64 → Vill = 1, Vl = 0, RdData = 0. Then at e32/m2: vadd.vv v3,v8,v12 → IllegalInstr; vadd.vv with vl = 0 → InstrDone, no micro-op.

Source files
------------

// File: rtl/vec_uop_sequencer.sv
// Vector control sequencer: holds vl/vtype, executes vsetvli/vsetivli and cracks
// unit-stride loads/stores and OPIVV/OPIVX/OPIVI ops into LANES-wide micro-ops.
module vec_uop_sequencer #(
   parameter int VLEN  = 128,
   parameter int LANES = 4,
   parameter int XLEN  = 32,
   parameter int VLW   = $clog2(VLEN) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      Instr,
   input  logic [XLEN-1:0]  Rs1Data,
   output logic             uop_valid,
   input  logic             uop_ready,
   output logic [1:0]       UopType,
   output logic [5:0]       Funct6,
   output logic [2:0]       Funct3,
   output logic [4:0]       VdIdx,
   output logic [4:0]       Vs1Idx,
   output logic [4:0]       Vs2Idx,
   output logic [VLW-1:0]   ElemBase,
   output logic [LANES-1:0] ElemMask,
   output logic [1:0]       Sew,
   output logic [XLEN-1:0]  ScalarOpd,
   output logic             VRegWrite,
   output logic             VMemRead,
   output logic             VMemWrite,
   output logic             UopLast,
   output logic [VLW-1:0]   Vl,
   output logic             Vill,
   output logic             RdWrite,
   output logic [XLEN-1:0]  RdData,
   output logic             InstrDone,
   output logic             IllegalInstr
);
   localparam int SH0 = $clog2(VLEN) - 3;

   typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

   state_t         r_state;
   logic [1:0]     r_lmul;
   logic [4:0]     r_vd_f, r_vs1_f, r_vs2_f;

   logic [6:0]     w_opcode;
   logic [2:0]     w_funct3;
   logic [4:0]     w_rd, w_rs1, w_rs2;
   logic           w_is_vset, w_is_alu, w_is_ld, w_is_st, w_is_vop;
   logic           w_vset_ok, w_vset_ill;
   logic [2:0]     w_vs_sew, w_vs_lmul;
   logic [XLEN-1:0] w_vlmax, w_avl;
   logic [VLW-1:0] w_new_vl;
   logic [4:0]     w_align;
   logic           w_mis, w_eew_ok, w_mem_ok, w_vop_bad;
   logic           w_start, w_load_uop;
   logic [VLW:0]   w_sel_base;
   logic [4:0]     w_shift, w_sel_off;
   logic           w_sel_last;
   logic [LANES-1:0] w_sel_mask;
   logic [4:0]     w_vd_src, w_vs1_src, w_vs2_src;

   assign w_opcode  = Instr[6:0];
   assign w_funct3  = Instr[14:12];
   assign w_rd      = Instr[11:7];
   assign w_rs1     = Instr[19:15];
   assign w_rs2     = Instr[24:20];
   assign w_is_vset = (w_opcode == 7'b1010111) && (w_funct3 == 3'b111);
   assign w_is_alu  = (w_opcode == 7'b1010111) &&
                      ((w_funct3 == 3'b000) || (w_funct3 == 3'b100) || (w_funct3 == 3'b011));
   assign w_is_ld   = (w_opcode == 7'b0000111);
   assign w_is_st   = (w_opcode == 7'b0100111);
   assign w_is_vop  = w_is_alu | w_is_ld | w_is_st;

   // vsetvli and vsetivli place vsew/vlmul at the same bit positions
   assign w_vset_ok  = !Instr[31] || Instr[30];
   assign w_vs_sew   = Instr[25:23];
   assign w_vs_lmul  = Instr[22:20];
   assign w_vset_ill = (w_vs_sew > 3'd2) | w_vs_lmul[2];
   assign w_vlmax    = (XLEN'(VLEN) << w_vs_lmul[1:0]) >> (3 + w_vs_sew[1:0]);

   always_comb begin
      w_avl = Rs1Data;
      if (Instr[31])          w_avl = XLEN'(Instr[19:15]);
      else if (w_rs1 != 5'd0) w_avl = Rs1Data;
      else if (w_rd != 5'd0)  w_avl = w_vlmax;
      else                    w_avl = XLEN'(Vl);
   end

   assign w_new_vl = w_vset_ill ? '0 : VLW'((w_avl < w_vlmax) ? w_avl : w_vlmax);

   assign w_align = (5'd1 << r_lmul) - 5'd1;
   assign w_mis   = (|(w_rd & w_align)) |
                    (w_is_alu & |(w_rs2 & w_align)) |
                    (w_is_alu & (w_funct3 == 3'b000) & |(w_rs1 & w_align));

   always_comb begin
      case (w_funct3)
         3'b000:  w_eew_ok = (Sew == 2'd0);
         3'b101:  w_eew_ok = (Sew == 2'd1);
         3'b110:  w_eew_ok = (Sew == 2'd2);
         default: w_eew_ok = 1'b0;
      endcase
   end

   assign w_mem_ok  = (Instr[31:29] == 3'd0) && (Instr[27:26] == 2'd0) &&
                      (Instr[24:20] == 5'd0) && w_eew_ok;
   assign w_vop_bad = !Instr[25] | Vill | w_mis | ((w_is_ld | w_is_st) & !w_mem_ok);

   assign w_start    = (r_state == S_IDLE) & in_valid & w_is_vop & !w_vop_bad & (Vl != '0);
   assign w_load_uop = w_start | ((r_state == S_ISSUE) & uop_ready & !UopLast);

   // Element base of the micro-op about to be presented: 0 on accept, else next group
   assign w_sel_base = (r_state == S_IDLE) ? '0 : ({1'b0, ElemBase} + (VLW+1)'(LANES));
   assign w_shift    = 5'(SH0) - {3'b000, Sew};
   assign w_sel_off  = 5'(w_sel_base >> w_shift);
   assign w_sel_last = (w_sel_base + (VLW+1)'(LANES)) >= {1'b0, Vl};

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_mask
         assign w_sel_mask[gi] = (w_sel_base + (VLW+1)'(gi)) < {1'b0, Vl};
      end
   endgenerate

   assign w_vd_src  = (r_state == S_IDLE) ? w_rd  : r_vd_f;
   assign w_vs1_src = (r_state == S_IDLE) ? w_rs1 : r_vs1_f;
   assign w_vs2_src = (r_state == S_IDLE) ? w_rs2 : r_vs2_f;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         in_ready     <= 1'b1;
         uop_valid    <= 1'b0;
         Vl           <= '0;
         Vill         <= 1'b1;
         Sew          <= 2'd0;
         r_lmul       <= 2'd0;
         RdWrite      <= 1'b0;
         RdData       <= '0;
         InstrDone    <= 1'b0;
         IllegalInstr <= 1'b0;
      end else begin
         RdWrite      <= 1'b0;
         InstrDone    <= 1'b0;
         IllegalInstr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_is_vset) begin
                     if (!w_vset_ok) begin
                        IllegalInstr <= 1'b1;
                     end else begin
                        Vl        <= w_new_vl;
                        Vill      <= w_vset_ill;
                        Sew       <= w_vset_ill ? 2'd0 : w_vs_sew[1:0];
                        r_lmul    <= w_vset_ill ? 2'd0 : w_vs_lmul[1:0];
                        RdWrite   <= (w_rd != 5'd0);
                        RdData    <= XLEN'(w_new_vl);
                        InstrDone <= 1'b1;
                     end
                  end else if (w_is_vop) begin
                     if (w_vop_bad) begin
                        IllegalInstr <= 1'b1;
                     end else if (Vl == '0) begin
                        InstrDone <= 1'b1;
                     end else begin
                        r_state   <= S_ISSUE;
                        in_ready  <= 1'b0;
                        uop_valid <= 1'b1;
                        UopType   <= w_is_ld ? 2'd1 : (w_is_st ? 2'd2 : 2'd0);
                        Funct6    <= Instr[31:26];
                        Funct3    <= w_funct3;
                        ScalarOpd <= (w_funct3 == 3'b011) ? {{(XLEN-5){Instr[19]}}, Instr[19:15]}
                                                          : Rs1Data;
                        VRegWrite <= w_is_alu | w_is_ld;
                        VMemRead  <= w_is_ld;
                        VMemWrite <= w_is_st;
                        r_vd_f    <= w_rd;
                        r_vs1_f   <= w_rs1;
                        r_vs2_f   <= w_rs2;
                     end
                  end else begin
                     IllegalInstr <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (uop_ready && UopLast) begin
                  r_state   <= S_IDLE;
                  in_ready  <= 1'b1;
                  uop_valid <= 1'b0;
                  InstrDone <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_load_uop) begin
            ElemBase <= w_sel_base[VLW-1:0];
            ElemMask <= w_sel_mask;
            UopLast  <= w_sel_last;
            VdIdx    <= w_vd_src + w_sel_off;
            Vs1Idx   <= w_vs1_src + w_sel_off;
            Vs2Idx   <= w_vs2_src + w_sel_off;
         end
      end
   end
endmodule

// File: tb/tb_vec_uop_sequencer.sv
// Randomised bench for vec_uop_sequencer: an instruction-level model predicts every
// cycle's outputs; a short directed prologue pins the model with literal values.
module tb_vec_uop_sequencer;
   localparam int VLEN  = 128;
   localparam int LANES = 4;
   localparam int XLEN  = 32;
   localparam int VLW   = $clog2(VLEN) + 1;

   logic clk = 1'b0;
   logic rst_n, in_valid, in_ready, uop_valid, uop_ready;
   logic [31:0] Instr;
   logic [XLEN-1:0] Rs1Data, ScalarOpd, RdData;
   logic [1:0] UopType, Sew;
   logic [5:0] Funct6;
   logic [2:0] Funct3;
   logic [4:0] VdIdx, Vs1Idx, Vs2Idx;
   logic [VLW-1:0] ElemBase, Vl;
   logic [LANES-1:0] ElemMask;
   logic VRegWrite, VMemRead, VMemWrite, UopLast, Vill, RdWrite, InstrDone, IllegalInstr;

   always #5 clk = ~clk;

   vec_uop_sequencer #(.VLEN(VLEN), .LANES(LANES), .XLEN(XLEN), .VLW(VLW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .Instr(Instr), .Rs1Data(Rs1Data), .uop_valid(uop_valid), .uop_ready(uop_ready),
      .UopType(UopType), .Funct6(Funct6), .Funct3(Funct3),
      .VdIdx(VdIdx), .Vs1Idx(Vs1Idx), .Vs2Idx(Vs2Idx),
      .ElemBase(ElemBase), .ElemMask(ElemMask), .Sew(Sew), .ScalarOpd(ScalarOpd),
      .VRegWrite(VRegWrite), .VMemRead(VMemRead), .VMemWrite(VMemWrite), .UopLast(UopLast),
      .Vl(Vl), .Vill(Vill), .RdWrite(RdWrite), .RdData(RdData),
      .InstrDone(InstrDone), .IllegalInstr(IllegalInstr));

   typedef struct {
      logic [1:0] typ;
      logic [5:0] f6;
      logic [2:0] f3;
      logic [4:0] vd, vs1, vs2;
      int         base;
      logic [LANES-1:0] mask;
      logic [31:0] sc;
      bit         chk_sc;
      logic       rw, mr, mw, last;
      logic [1:0] sew;
   } uop_t;

   int   n_vec = 0, n_err = 0;
   int   m_vl, m_sew, m_lmul;
   bit   m_vill;
   uop_t uq[$];
   bit   e_rdw, e_done, e_ill;
   logic [31:0] e_rdd;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int eew_of(input logic [2:0] w);
      case (w)
         3'b000:  return 0;
         3'b101:  return 1;
         3'b110:  return 2;
         default: return -1;
      endcase
   endfunction

   task automatic model_accept(input logic [31:0] ins, input logic [31:0] rs);
      logic [6:0] opc = ins[6:0];
      logic [2:0] f3  = ins[14:12];
      int rd = ins[11:7], r1 = ins[19:15], r2 = ins[24:20];
      bit alu = (opc == 7'h57) && (f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd3);
      bit ld  = (opc == 7'h07);
      bit st  = (opc == 7'h27);
      if (opc == 7'h57 && f3 == 3'd7) begin
         if (ins[31:30] == 2'b10) begin
            e_ill = 1;
         end else begin
            int sew = ins[25:23], lmul = ins[22:20];
            longint unsigned avl, vlmax;
            if (ins[31])        avl = ins[19:15];
            else if (r1 != 0)   avl = rs;
            else if (rd != 0)   avl = 64'hFFFF_FFFF_FFFF;
            else                avl = m_vl;
            if (sew > 2 || lmul > 3) begin
               m_vill = 1; m_vl = 0; m_sew = 0; m_lmul = 0;
            end else begin
               vlmax  = (VLEN * (1 << lmul)) / (8 * (1 << sew));
               m_vill = 0; m_sew = sew; m_lmul = lmul;
               m_vl   = int'((avl < vlmax) ? avl : vlmax);
            end
            e_rdw = (rd != 0); e_rdd = m_vl; e_done = 1;
         end
      end else if (alu || ld || st) begin
         int lm = 1 << m_lmul;
         bit bad = !ins[25] || m_vill || (rd % lm != 0);
         if (alu && (r2 % lm != 0)) bad = 1;
         if (alu && f3 == 3'd0 && (r1 % lm != 0)) bad = 1;
         if ((ld || st) && (ins[31:29] != 0 || ins[27:26] != 0 || ins[24:20] != 0 ||
                            eew_of(f3) != m_sew)) bad = 1;
         if (bad) e_ill = 1;
         else if (m_vl == 0) e_done = 1;
         else begin
            int epr = VLEN / (8 << m_sew);
            int n   = (m_vl + LANES - 1) / LANES;
            for (int k = 0; k < n; k++) begin
               uop_t u;
               int off;
               u.base = k * LANES;
               off    = u.base / epr;
               u.typ  = ld ? 2'd1 : (st ? 2'd2 : 2'd0);
               u.f6   = ins[31:26];
               u.f3   = f3;
               u.vd   = 5'((rd + off) % 32);
               u.vs1  = 5'((r1 + off) % 32);
               u.vs2  = 5'((r2 + off) % 32);
               for (int i = 0; i < LANES; i++) u.mask[i] = (u.base + i < m_vl);
               u.chk_sc = !(alu && f3 == 3'd0);
               u.sc   = (alu && f3 == 3'd3) ? {{27{ins[19]}}, ins[19:15]} : rs;
               u.rw   = alu || ld;
               u.mr   = ld;
               u.mw   = st;
               u.last = (k == n - 1);
               u.sew  = 2'(m_sew);
               uq.push_back(u);
            end
         end
      end else begin
         e_ill = 1;
      end
   endtask

   task automatic model_step(input logic rst, input logic v, input logic [31:0] ins,
                             input logic [31:0] rs, input logic rdy);
      e_rdw = 0; e_done = 0; e_ill = 0;
      if (rst) begin
         m_vl = 0; m_vill = 1; m_sew = 0; m_lmul = 0;
         uq.delete();
      end else if (uq.size() != 0) begin
         if (rdy) begin
            void'(uq.pop_front());
            if (uq.size() == 0) e_done = 1;
         end
      end else if (v) begin
         model_accept(ins, rs);
      end
   endtask

   task automatic compare_all();
      chk("in_ready", in_ready, uq.size() == 0);
      chk("uop_valid", uop_valid, uq.size() != 0);
      chk("Vl", Vl, m_vl);
      chk("Vill", Vill, m_vill);
      chk("RdWrite", RdWrite, e_rdw);
      chk("InstrDone", InstrDone, e_done);
      chk("IllegalInstr", IllegalInstr, e_ill);
      if (e_rdw) chk("RdData", RdData, e_rdd);
      if (uq.size() != 0) begin
         chk("UopType", UopType, uq[0].typ);
         chk("Funct6", Funct6, uq[0].f6);
         chk("Funct3", Funct3, uq[0].f3);
         chk("VdIdx", VdIdx, uq[0].vd);
         chk("Vs1Idx", Vs1Idx, uq[0].vs1);
         chk("Vs2Idx", Vs2Idx, uq[0].vs2);
         chk("ElemBase", ElemBase, uq[0].base);
         chk("ElemMask", ElemMask, uq[0].mask);
         chk("Sew", Sew, uq[0].sew);
         chk("VRegWrite", VRegWrite, uq[0].rw);
         chk("VMemRead", VMemRead, uq[0].mr);
         chk("VMemWrite", VMemWrite, uq[0].mw);
         chk("UopLast", UopLast, uq[0].last);
         if (uq[0].chk_sc) chk("ScalarOpd", ScalarOpd, uq[0].sc);
      end
   endtask

   // Drive one cycle of inputs at a negedge, predict, then check at the next negedge
   task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [31:0] rs, input logic rdy);
      rst_n = !rst; in_valid = v; Instr = ins; Rs1Data = rs; uop_ready = rdy;
      model_step(rst, v, ins, rs, rdy);
      @(negedge clk);
      compare_all();
   endtask

   function automatic logic [31:0] vsetvli(input int rd, input int rs1, input int sew, input int lmul);
      return {1'b0, 5'd0, 3'(sew), 3'(lmul), 5'(rs1), 3'b111, 5'(rd), 7'h57};
   endfunction
   function automatic logic [31:0] vsetivli(input int rd, input int uimm, input int sew, input int lmul);
      return {2'b11, 4'd0, 3'(sew), 3'(lmul), 5'(uimm), 3'b111, 5'(rd), 7'h57};
   endfunction
   function automatic logic [31:0] valu(input int f6, input int vm, input int vs2,
                                        input int vs1, input int f3, input int vd);
      return {6'(f6), 1'(vm), 5'(vs2), 5'(vs1), 3'(f3), 5'(vd), 7'h57};
   endfunction
   function automatic logic [31:0] vmem(input bit st, input int nf, input int mop, input int vm,
                                        input int lumop, input int rs1, input int w, input int vd);
      return {3'(nf), 1'b0, 2'(mop), 1'(vm), 5'(lumop), 5'(rs1), 3'(w), 5'(vd),
              st ? 7'h27 : 7'h07};
   endfunction

   function automatic int rreg();
      int r = $urandom_range(0, 31);
      if ($urandom_range(0, 3) != 0) r = r & ~((1 << m_lmul) - 1);
      return r;
   endfunction

   task automatic gen(output logic [31:0] ins, output logic [31:0] rs);
      int r    = $urandom_range(0, 99);
      int sew  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      int lmul = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      int rd   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      int r1   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      int vm   = ($urandom_range(0, 15) != 0) ? 1 : 0;
      int f3s[3] = '{0, 4, 3};
      int ws[3]  = '{0, 5, 6};
      rs = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 40);
      if (r < 20)      ins = vsetvli(rd, r1, sew, lmul);
      else if (r < 28) ins = vsetivli(rd, $urandom_range(0, 31), sew, lmul);
      else if (r < 30) ins = {2'b10, 5'($urandom), 5'($urandom), 5'($urandom), 3'b111,
                              5'($urandom), 7'h57};
      else if (r < 70) ins = valu($urandom_range(0, 63), vm, rreg(), rreg(),
                                  f3s[$urandom_range(0, 2)], rreg());
      else if (r < 92) ins = vmem($urandom_range(0, 1) == 1,
                                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 7) : 0,
                                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0, vm,
                                  ($urandom_range(0, 9) == 0) ? $urandom_range(1, 31) : 0,
                                  r1, ws[$urandom_range(0, 2)], rreg());
      else             ins = $urandom;
   endtask

   initial begin
      logic [31:0] ins, rs;
      rst_n = 1'b0; in_valid = 1'b0; Instr = '0; Rs1Data = '0; uop_ready = 1'b0;
      @(negedge clk);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      // vadd.vv after reset: vtype illegal
      step(0, 1, valu(0, 1, 2, 3, 0, 1), 0, 1);
      chk("pin_ill_after_reset", IllegalInstr, 1);
      chk("pin_vill_reset", Vill, 1);

      // vsetvli x5,x6,e32,m2 with AVL 10 -> vl 8
      step(0, 1, vsetvli(5, 6, 2, 1), 10, 1);
      chk("pin_vl8", Vl, 8);
      chk("pin_rddata8", RdData, 8);
      chk("pin_model_vl8", m_vl, 8);
      step(0, 1, vsetvli(0, 0, 2, 1), 0, 1);
      chk("pin_keep_vl", Vl, 8);
      chk("pin_no_rdwrite", RdWrite, 0);

      // vadd.vv v4,v8,v12 -> two micro-ops
      step(0, 1, valu(0, 1, 8, 12, 0, 4), 0, 1);
      chk("pin_vd0", VdIdx, 4);
      chk("pin_base0", ElemBase, 0);
      step(0, 0, 0, 0, 1);
      chk("pin_vd1", VdIdx, 5);
      chk("pin_vs2_1", Vs2Idx, 9);
      chk("pin_vs1_1", Vs1Idx, 13);
      chk("pin_last1", UopLast, 1);
      step(0, 0, 0, 0, 1);
      chk("pin_done_vadd", InstrDone, 1);

      // vsetivli x0,6,e8,m1 then vle8.v v2,(x1)
      step(0, 1, vsetivli(0, 6, 0, 0), 0, 1);
      step(0, 1, vmem(0, 0, 0, 1, 0, 1, 0, 2), 32'h1000, 1);
      chk("pin_mask0", ElemMask, 4'b1111);
      chk("pin_scalar", ScalarOpd, 32'h1000);
      step(0, 0, 0, 0, 1);
      chk("pin_mask1", ElemMask, 4'b0011);
      chk("pin_ld_vd1", VdIdx, 2);
      step(0, 0, 0, 0, 1);

      // stall three cycles, advance once, then reset mid-issue
      step(0, 1, valu(0, 1, 8, 12, 0, 4), 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      chk("pin_stall_base", ElemBase, 0);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      chk("pin_rst_uopv", uop_valid, 0);
      chk("pin_rst_done", InstrDone, 0);
      step(0, 0, 0, 0, 0);

      // e64 -> vill; misaligned vd; vl = 0
      step(0, 1, vsetvli(5, 6, 3, 0), 10, 1);
      chk("pin_e64_rddata", RdData, 0);
      chk("pin_e64_vill", Vill, 1);
      step(0, 1, vsetvli(5, 6, 2, 1), 10, 1);
      step(0, 1, valu(0, 1, 8, 12, 0, 3), 0, 1);
      chk("pin_misaligned", IllegalInstr, 1);
      step(0, 1, vsetvli(5, 6, 2, 1), 0, 1);
      step(0, 1, valu(0, 1, 8, 12, 0, 4), 0, 1);
      chk("pin_vl0_done", InstrDone, 1);
      chk("pin_vl0_nouop", uop_valid, 0);

      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            step(1, 0, 0, 0, 0);
         end else begin
            gen(ins, rs);
            step(0, $urandom_range(0, 2) != 0, ins, rs, $urandom_range(0, 3) != 0);
         end
      end
      for (int c = 0; c < 40; c++) step(0, 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
